// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one SPI master between NREQ requesters.
// One 1..3 byte transaction at a time, round-robin grant, per-byte
// timeout, and a minimum chip-select idle gap between transactions.
module spi_txn_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1023,
    parameter int CSGAP   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_chip,
    input  logic [2*NREQ-1:0]    req_nbytes,
    input  logic [24*NREQ-1:0]   req_bytes,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [7:0]           spitx,
    output logic                 spitxdv,
    input  logic                 spitxready,
    input  logic [7:0]           spirx,
    input  logic                 spirxdv,
    output logic [7:0]           spics,
    output logic [2:0]           spimisossel
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    typedef logic [PW-1:0] idx_t;
    typedef logic [PW:0]   cand_t;

    // Last count value before giving up, and last gap cycle before IDLE.
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
    localparam logic [9:0] GAP_LAST = 10'(CSGAP - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        WAIT_RDY = 3'd2,
        PULSE    = 3'd3,
        HOLD     = 3'd4,
        WAIT_RX  = 3'd5,
        DONE     = 3'd6,
        GAP      = 3'd7
    } state_t;

    // One-hot vector with bit i set.
    function automatic logic [NREQ-1:0] onehot(input idx_t i);
        logic [NREQ-1:0] v;
        for (int k = 0; k < NREQ; k++) begin
            v[k] = (i == idx_t'(k));
        end
        return v;
    endfunction

    // Pick byte i out of a 3-byte payload.
    function automatic logic [7:0] byte_sel(input logic [23:0] b, input logic [1:0] i);
        logic [7:0] r;
        case (i)
            2'd0:    r = b[7:0];
            2'd1:    r = b[15:8];
            default: r = b[23:16];
        endcase
        return r;
    endfunction

    // Active-low chip select pattern for one chip.
    function automatic logic [7:0] cs_mask(input logic [2:0] chip);
        return ~(8'h01 << chip);
    endfunction

    // Unpacked views of the per-requester fields.
    logic [2:0]  chip_a   [NREQ];
    logic [1:0]  nbytes_a [NREQ];
    logic [23:0] bytes_a  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign chip_a[g]   = req_chip[3*g +: 3];
        assign nbytes_a[g] = req_nbytes[2*g +: 2];
        assign bytes_a[g]  = req_bytes[24*g +: 24];
    end

    state_t          state_r, state_next_s;
    logic [9:0]      cnt_r, cnt_next_s;
    idx_t            ptr_r, ptr_next_s;
    idx_t            owner_r, owner_next_s;
    logic [2:0]      chip_r, chip_next_s;
    logic [1:0]      nbytes_r, nbytes_next_s;
    logic [23:0]     bytes_r, bytes_next_s;
    logic [1:0]      byte_idx_r, byte_idx_next_s;
    logic [7:0]      rx_r, rx_next_s;
    logic            err_r, err_next_s;
    logic [7:0]      spics_r, spics_next_s;
    logic [7:0]      spitx_r, spitx_next_s;
    logic            spitxdv_r, spitxdv_next_s;
    logic [2:0]      misosel_r, misosel_next_s;
    logic [NREQ-1:0] rsp_valid_r, rsp_valid_next_s;
    logic [7:0]      rsp_data_r, rsp_data_next_s;
    logic            rsp_err_r, rsp_err_next_s;
    logic [NREQ-1:0] req_ready_s;

    logic            grant_found_s;
    idx_t            grant_s;
    cand_t           cand_s;
    logic            hit_s;

    // Round-robin scan: first asserted req_valid at or above the pointer, with wrap.
    always_comb begin
        grant_found_s = 1'b0;
        grant_s       = '0;
        cand_s        = '0;
        hit_s         = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s        = {1'b0, ptr_r} + cand_t'(k);
            cand_s        = (cand_s >= cand_t'(NREQ)) ? (cand_s - cand_t'(NREQ)) : cand_s;
            hit_s         = !grant_found_s && req_valid[cand_s[PW-1:0]];
            grant_s       = hit_s ? cand_s[PW-1:0] : grant_s;
            grant_found_s = grant_found_s | hit_s;
        end
    end

    // Next-state and next-register values for the transaction sequencer.
    always_comb begin
        state_next_s     = state_r;
        ptr_next_s       = ptr_r;
        owner_next_s     = owner_r;
        chip_next_s      = chip_r;
        nbytes_next_s    = nbytes_r;
        bytes_next_s     = bytes_r;
        byte_idx_next_s  = byte_idx_r;
        rx_next_s        = rx_r;
        err_next_s       = err_r;
        spics_next_s     = spics_r;
        spitx_next_s     = spitx_r;
        spitxdv_next_s   = 1'b0;
        misosel_next_s   = misosel_r;
        rsp_valid_next_s = '0;
        rsp_data_next_s  = rsp_data_r;
        rsp_err_next_s   = rsp_err_r;
        req_ready_s      = '0;

        case (state_r)
            IDLE: begin
                if (grant_found_s) begin
                    req_ready_s     = onehot(grant_s);
                    owner_next_s    = grant_s;
                    chip_next_s     = chip_a[grant_s];
                    nbytes_next_s   = nbytes_a[grant_s];
                    bytes_next_s    = bytes_a[grant_s];
                    byte_idx_next_s = 2'd0;
                    if (nbytes_a[grant_s] == 2'd0) begin
                        // Illegal length: report an error without touching the SPI pins.
                        err_next_s   = 1'b1;
                        rx_next_s    = 8'hFF;
                        state_next_s = DONE;
                    end else begin
                        err_next_s   = 1'b0;
                        rx_next_s    = 8'h00;
                        state_next_s = SELECT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            SELECT: begin
                spics_next_s   = cs_mask(chip_r);
                misosel_next_s = chip_r;
                spitx_next_s   = bytes_r[7:0];
                state_next_s   = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (spitxready) begin
                    spitxdv_next_s = 1'b1;
                    state_next_s   = PULSE;
                end else if (cnt_r == TMO_LAST) begin
                    err_next_s   = 1'b1;
                    rx_next_s    = 8'hFF;
                    state_next_s = DONE;
                end else begin
                    state_next_s = WAIT_RDY;
                end
            end
            PULSE: begin
                if (byte_idx_r == (nbytes_r - 2'd1)) begin
                    state_next_s = WAIT_RX;
                end else begin
                    byte_idx_next_s = byte_idx_r + 2'd1;
                    spitx_next_s    = byte_sel(bytes_r, byte_idx_r + 2'd1);
                    state_next_s    = HOLD;
                end
            end
            HOLD: begin
                // Gives the master a cycle to drop spitxready after the strobe.
                state_next_s = WAIT_RDY;
            end
            WAIT_RX: begin
                // Earlier bytes' rx strobes land in WAIT_RDY/HOLD, so the first one here is the last byte.
                if (spirxdv) begin
                    rx_next_s    = spirx;
                    state_next_s = DONE;
                end else if (cnt_r == TMO_LAST) begin
                    err_next_s   = 1'b1;
                    rx_next_s    = 8'hFF;
                    state_next_s = DONE;
                end else begin
                    state_next_s = WAIT_RX;
                end
            end
            DONE: begin
                spics_next_s     = 8'hFF;
                rsp_valid_next_s = onehot(owner_r);
                rsp_data_next_s  = rx_r;
                rsp_err_next_s   = err_r;
                ptr_next_s       = (owner_r == idx_t'(NREQ - 1)) ? idx_t'(0) : (owner_r + idx_t'(1));
                state_next_s     = GAP;
            end
            GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = GAP;
                end
            end
            default: begin
                spics_next_s = 8'hFF;
                state_next_s = IDLE;
            end
        endcase

        // One counter serves both timeouts and the gap: it restarts on every state change.
        if ((state_next_s != state_r) || (state_r == IDLE)) begin
            cnt_next_s = 10'd0;
        end else begin
            cnt_next_s = cnt_r + 10'd1;
        end
    end

    // State and datapath registers; reset returns every pin to its idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 10'd0;
            ptr_r       <= '0;
            owner_r     <= '0;
            chip_r      <= 3'd0;
            nbytes_r    <= 2'd0;
            bytes_r     <= 24'd0;
            byte_idx_r  <= 2'd0;
            rx_r        <= 8'd0;
            err_r       <= 1'b0;
            spics_r     <= 8'hFF;
            spitx_r     <= 8'd0;
            spitxdv_r   <= 1'b0;
            misosel_r   <= 3'd0;
            rsp_valid_r <= '0;
            rsp_data_r  <= 8'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            ptr_r       <= ptr_next_s;
            owner_r     <= owner_next_s;
            chip_r      <= chip_next_s;
            nbytes_r    <= nbytes_next_s;
            bytes_r     <= bytes_next_s;
            byte_idx_r  <= byte_idx_next_s;
            rx_r        <= rx_next_s;
            err_r       <= err_next_s;
            spics_r     <= spics_next_s;
            spitx_r     <= spitx_next_s;
            spitxdv_r   <= spitxdv_next_s;
            misosel_r   <= misosel_next_s;
            rsp_valid_r <= rsp_valid_next_s;
            rsp_data_r  <= rsp_data_next_s;
            rsp_err_r   <= rsp_err_next_s;
        end
    end

    assign req_ready   = req_ready_s;
    assign busy        = (state_r != IDLE);
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_err     = rsp_err_r;
    assign spitx       = spitx_r;
    assign spitxdv     = spitxdv_r;
    assign spics       = spics_r;
    assign spimisossel = misosel_r;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed testbench for spi_txn_arbiter with a simple SPI master model.
module tb_spi_txn_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [5:0]  req_chip = 6'd0;
    logic [3:0]  req_nbytes = 4'd0;
    logic [47:0] req_bytes = 48'd0;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  spitx;
    logic        spitxdv;
    logic        spitxready = 1'b0;
    logic [7:0]  spirx = 8'd0;
    logic        spirxdv = 1'b0;
    logic [7:0]  spics;
    logic [2:0]  spimisossel;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // SPI master model state (0 = normal, 1 = spitxready stuck low)
    int         m_mode = 0;
    int         m_cnt  = 0;
    int         m_busy = 0;
    int         m_n    = 0;
    logic [7:0] rx_tbl [8];

    // Monitors
    int         dv_cnt = 0;
    logic [7:0] dv_log [8];
    logic       prev_dv = 1'b0;
    int         dv_consec = 0;
    int         first_cs = -1;
    int         first_dv = -1;
    logic [7:0] cs_expect = 8'hFF;
    logic [2:0] sel_expect = 3'd0;
    int         cs_bad = 0;
    int         sel_bad = 0;
    int         ff_run = 0;
    int         seen_low = 0;
    int         gap_viol = 0;
    int         rr_multi = 0;
    int         grant_cnt = 0;
    int         grant_log [16];
    int         rsp_total = 0;
    logic [1:0] rsp_vec_log [16];
    logic [7:0] rsp_data_log [16];

    spi_txn_arbiter #(.NREQ(2), .TIMEOUT(1023), .CSGAP(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_chip(req_chip), .req_nbytes(req_nbytes), .req_bytes(req_bytes),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .spitx(spitx), .spitxdv(spitxdv), .spitxready(spitxready),
        .spirx(spirx), .spirxdv(spirxdv), .spics(spics), .spimisossel(spimisossel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors and SPI master model, evaluated away from the active edge.
    always @(negedge clk) begin
        if (rsp_valid != 2'b00) begin
            if (rsp_total < 16) begin
                rsp_vec_log[rsp_total]  = rsp_valid;
                rsp_data_log[rsp_total] = rsp_data;
            end
            rsp_total++;
        end
        if ($countones(req_ready) > 1) rr_multi++;
        if (req_ready != 2'b00) begin
            if (grant_cnt < 16) grant_log[grant_cnt] = req_ready[1] ? 1 : 0;
            grant_cnt++;
        end
        if (spitxdv) begin
            if (dv_cnt < 8) dv_log[dv_cnt] = spitx;
            dv_cnt++;
            if (prev_dv) dv_consec++;
            if (first_dv < 0) first_dv = cyc;
        end
        prev_dv = spitxdv;
        if (spics != 8'hFF) begin
            if (first_cs < 0) first_cs = cyc;
            if (spics != cs_expect) cs_bad++;
            if (spimisossel != sel_expect) sel_bad++;
            if (seen_low != 0 && ff_run > 0 && ff_run < 4) gap_viol++;
            ff_run = 0;
            seen_low = 1;
        end else begin
            ff_run++;
        end

        spirxdv = 1'b0;
        if (m_mode == 1) begin
            spitxready = 1'b0;
            m_busy = 0;
        end else if (spitxdv) begin
            spitxready = 1'b0;
            m_cnt = 0;
            m_busy = 1;
        end else if (m_busy != 0) begin
            m_cnt++;
            if (m_cnt == 15) begin
                spirx = rx_tbl[m_n % 8];
                spirxdv = 1'b1;
                m_n++;
            end
            if (m_cnt == 16) begin
                spitxready = 1'b1;
                m_busy = 0;
            end
        end else begin
            spitxready = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for acceptance and for the response.
    task automatic do_txn(input int r, input logic [2:0] chip, input logic [1:0] nb,
                          input logic [23:0] bytes, output logic [1:0] vec,
                          output logic [7:0] data, output logic err, output int lat);
        int n;
        int acc;
        req_chip[3*r +: 3]    = chip;
        req_nbytes[2*r +: 2]  = nb;
        req_bytes[24*r +: 24] = bytes;
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (req_ready[r] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("accept", 32'(req_ready[r]), 32'd1);
        first_cs = -1;
        first_dv = -1;
        dv_cnt   = 0;
        step();
        acc = cyc;
        req_valid[r] = 1'b0;
        n = 0;
        while (rsp_valid === 2'b00 && n < 2000) begin
            step();
            n++;
        end
        vec  = rsp_valid;
        data = rsp_data;
        err  = rsp_err;
        lat  = cyc - acc;
    endtask

    initial begin
        logic [1:0] vec;
        logic [7:0] data;
        logic       err;
        int         lat;
        int         n;
        int         rsp_before;

        // Reset state
        rst = 1'b1;
        step(); step(); step();
        check("rst_spics", 32'(spics), 32'hFF);
        check("rst_spitxdv", 32'(spitxdv), 32'd0);
        check("rst_spitx", 32'(spitx), 32'd0);
        check("rst_misosel", 32'(spimisossel), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step(); step();

        // Test 1: req0, chip 2, 3 bytes AA BB CC, rx 11 22 33
        rx_tbl[0] = 8'h11; rx_tbl[1] = 8'h22; rx_tbl[2] = 8'h33;
        m_n = 0;
        cs_expect = 8'hFB; sel_expect = 3'd2; cs_bad = 0; sel_bad = 0;
        do_txn(0, 3'd2, 2'd3, 24'hCCBBAA, vec, data, err, lat);
        check("t1_vec", 32'(vec), 32'd1);
        check("t1_data", 32'(data), 32'h33);
        check("t1_err", 32'(err), 32'd0);
        check("t1_lat", 32'(lat), 32'd53);
        check("t1_cs_lat", 32'(first_cs), 32'(cyc - lat + 1));
        check("t1_dv_lat", 32'(first_dv), 32'(cyc - lat + 2));
        check("t1_dv_cnt", 32'(dv_cnt), 32'd3);
        check("t1_byte0", 32'(dv_log[0]), 32'hAA);
        check("t1_byte1", 32'(dv_log[1]), 32'hBB);
        check("t1_byte2", 32'(dv_log[2]), 32'hCC);
        check("t1_cs_bad", 32'(cs_bad), 32'd0);
        check("t1_sel_bad", 32'(sel_bad), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t1_gap_cs", 32'(spics), 32'hFF);
            step();
        end
        step(); step();

        // Test 2: both requesting for 4 transactions from reset -> 0,1,0,1
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        rx_tbl[0] = 8'h01; rx_tbl[1] = 8'h02; rx_tbl[2] = 8'h03; rx_tbl[3] = 8'h04;
        m_n = 0;
        cs_expect = 8'hF7; sel_expect = 3'd3;
        req_chip   = {3'd3, 3'd3};
        req_nbytes = {2'd1, 2'd1};
        req_bytes  = {24'h0000B1, 24'h0000A0};
        grant_cnt = 0;
        rsp_total = 0;
        req_valid = 2'b11;
        n = 0;
        while (rsp_total < 4 && n < 400) begin
            step();
            n++;
        end
        req_valid = 2'b00;
        check("t2_rsp_total", 32'(rsp_total), 32'd4);
        check("t2_grant_cnt", 32'(grant_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t2_grant", 32'(grant_log[i]), 32'(i % 2));
            check("t2_rsp_owner", 32'(rsp_vec_log[i]), 32'(1 << (i % 2)));
            check("t2_rsp_data", 32'(rsp_data_log[i]), 32'(i + 1));
        end
        step(); step(); step(); step(); step(); step();

        // Test 3: req1, chip 5, 2 bytes, rx 44 55
        rx_tbl[0] = 8'h44; rx_tbl[1] = 8'h55;
        m_n = 0;
        cs_expect = 8'hDF; sel_expect = 3'd5; cs_bad = 0; sel_bad = 0;
        do_txn(1, 3'd5, 2'd2, 24'h00A55A, vec, data, err, lat);
        check("t3_vec", 32'(vec), 32'd2);
        check("t3_data", 32'(data), 32'h55);
        check("t3_err", 32'(err), 32'd0);
        check("t3_dv_cnt", 32'(dv_cnt), 32'd2);
        check("t3_byte0", 32'(dv_log[0]), 32'h5A);
        check("t3_byte1", 32'(dv_log[1]), 32'hA5);
        check("t3_cs_bad", 32'(cs_bad), 32'd0);
        check("t3_sel_bad", 32'(sel_bad), 32'd0);
        step(); step(); step(); step(); step(); step();

        // Test 4: spitxready stuck low -> timeout, then a normal transaction
        m_mode = 1;
        step(); step();
        cs_expect = 8'hFD; sel_expect = 3'd1; cs_bad = 0;
        do_txn(0, 3'd1, 2'd1, 24'h000042, vec, data, err, lat);
        check("t4_vec", 32'(vec), 32'd1);
        check("t4_err", 32'(err), 32'd1);
        check("t4_data", 32'(data), 32'hFF);
        check("t4_lat", 32'(lat), 32'd1025);
        check("t4_dv_cnt", 32'(dv_cnt), 32'd0);
        check("t4_cs_after", 32'(spics), 32'hFF);
        check("t4_cs_bad", 32'(cs_bad), 32'd0);
        m_mode = 0;
        step(); step(); step(); step(); step(); step();
        rx_tbl[0] = 8'h77;
        m_n = 0;
        cs_expect = 8'hF7; sel_expect = 3'd3;
        do_txn(1, 3'd3, 2'd1, 24'h000099, vec, data, err, lat);
        check("t4b_vec", 32'(vec), 32'd2);
        check("t4b_err", 32'(err), 32'd0);
        check("t4b_data", 32'(data), 32'h77);
        check("t4b_byte0", 32'(dv_log[0]), 32'h99);
        step(); step(); step(); step(); step(); step();

        // Test 5: nbytes == 0 -> immediate error, SPI pins untouched
        do_txn(0, 3'd6, 2'd0, 24'h123456, vec, data, err, lat);
        check("t5_vec", 32'(vec), 32'd1);
        check("t5_err", 32'(err), 32'd1);
        check("t5_data", 32'(data), 32'hFF);
        check("t5_lat_le2", 32'(lat <= 2), 32'd1);
        check("t5_cs_untouched", 32'(first_cs), 32'hFFFF_FFFF);
        check("t5_dv_untouched", 32'(dv_cnt), 32'd0);
        step(); step(); step(); step(); step(); step();

        // Test 6: reset in the middle of byte 2 of a 3-byte transaction
        cs_expect = 8'hEF; sel_expect = 3'd4;
        req_chip[5:3]    = 3'd4;
        req_nbytes[3:2]  = 2'd3;
        req_bytes[47:24] = 24'h332211;
        dv_cnt = 0;
        req_valid[1] = 1'b1;
        #1;
        n = 0;
        while (req_ready[1] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("t6_accept", 32'(req_ready[1]), 32'd1);
        step();
        req_valid[1] = 1'b0;
        n = 0;
        while (dv_cnt < 2 && n < 100) begin
            step();
            n++;
        end
        check("t6_two_bytes", 32'(dv_cnt), 32'd2);
        step(); step(); step(); step(); step();
        check("t6_cs_low", 32'(spics), 32'hEF);
        rsp_before = rsp_total;
        rst = 1'b1;
        step();
        check("t6_rst_cs", 32'(spics), 32'hFF);
        check("t6_rst_dv", 32'(spitxdv), 32'd0);
        check("t6_rst_rsp", 32'(rsp_valid), 32'd0);
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("t6_no_rsp", 32'(rsp_total), 32'(rsp_before));
        check("t6_busy", 32'(busy), 32'd0);

        // Pointer back at 0: both requesting -> requester 0 wins
        cs_expect = 8'hFE; sel_expect = 3'd0;
        req_chip   = {3'd0, 3'd0};
        req_nbytes = {2'd1, 2'd1};
        req_valid  = 2'b11;
        #1;
        n = 0;
        while (req_ready === 2'b00 && n < 50) begin
            step();
            n++;
        end
        check("t6_ptr_grant", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b00;
        n = 0;
        while (rsp_valid === 2'b00 && n < 200) begin
            step();
            n++;
        end
        check("t6_ptr_rsp", 32'(rsp_valid), 32'd1);

        // Global properties
        check("dv_never_back_to_back", 32'(dv_consec), 32'd0);
        check("cs_gap_min", 32'(gap_viol), 32'd0);
        check("ready_onehot", 32'(rr_multi), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares the single on-board SPI master between NREQ requesters, for example the USB command processor and a power-up ADC/PLL init sequencer.
- Accepts one 1–3 byte transaction at a time under round-robin arbitration.
- Drives chip select, MISO select and the byte-level handshake, then returns the last received byte to the winning requester.
- Adds a per-byte timeout and an enforced chip-select idle gap.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT, 1023, cycles allowed waiting for spitxready or spirxdv before abort
CSGAP, 4, minimum cycles spics stays all-ones between transactions

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester transaction request
req_ready  out  NREQ  accept strobe, one-hot, combinational
req_chip  in  3*NREQ  target chip index per requester (bits [3i+2:3i])
req_nbytes  in  2*NREQ  bytes to send: 1..3; 0 is illegal
req_bytes  in  24*NREQ  byte0 in [24i+7:24i], byte1 in [24i+15:24i+8], byte2 in [24i+23:24i+16]
rsp_valid  out  NREQ  one-cycle completion pulse to the owner
rsp_data  out  8  last SPI byte received (valid with rsp_valid)
rsp_err  out  1  transaction illegal or timed out (valid with rsp_valid)
busy  out  1  high in every state except IDLE
spitx  out  8  byte to SPI master
spitxdv  out  1  one-cycle send strobe
spitxready  in  1  SPI master ready for a byte
spirx  in  8  received byte
spirxdv  in  1  received-byte strobe
spics  out  8  active-low chip selects
spimisossel  out  3  MISO mux select

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst).
- Reset values: spics=8'hFF, spitxdv=0, spitx=0, spimisossel=0, rsp_valid=0, rsp_data=0, rsp_err=0, round-robin pointer=0, state=IDLE.
- Reset mid-transaction: on the next edge spics=FF, spitxdv=0, and no rsp_valid is issued.

States: IDLE, SELECT, WAIT_RDY, PULSE, HOLD, WAIT_RX, DONE, GAP.

- IDLE
  - Grant goes to the first asserted req_valid scanning from pointer upward, with wrap.
  - req_ready[grant]=1 in that same cycle; req_ready is 0 in all other states.
  - On acceptance, latch the owner's chip, nbytes and bytes, clear byte_idx, and go to SELECT.
  - If the latched nbytes==0: go straight to DONE with err=1 and rx=8'hFF; the SPI pins are never touched.
- SELECT: spics[chip]<=0 (others 1), spimisossel<=chip, spitx<=byte0, go to WAIT_RDY.
- WAIT_RDY: on spitxready=1, set spitxdv<=1 and go to PULSE.
- PULSE: spitxdv<=0.
  - If byte_idx==nbytes-1, go to WAIT_RX.
  - Otherwise increment byte_idx, set spitx<=next byte, go to HOLD.
- HOLD: one cycle so the master can drop spitxready; go to WAIT_RDY.
- WAIT_RX: the first spirxdv seen here belongs to the last byte. Capture spirx and go to DONE.
  - Rx strobes for earlier bytes occur before the next spitxready and are ignored.
- DONE:
  - spics<=FF.
  - rsp_valid[owner]=1 for exactly one cycle, with rsp_data and rsp_err.
  - pointer<=(owner+1) mod NREQ.
  - Go to GAP.
- GAP: count CSGAP cycles, then go to IDLE. No grant is possible during GAP.
- Timeout:
  - The 10-bit counter clears on every entry into WAIT_RDY or WAIT_RX.
  - If it reaches TIMEOUT while still waiting: force spitxdv=0 and go to DONE with err=1, rsp_data=8'hFF.
- Throughput: spitxdv is never high on two consecutive cycles. At most one outstanding transaction.
- Minimum latency, with spitxready held high and nbytes=1: accept edge → spics low after 1 cycle → spitxdv high 2 cycles after accept.
- Simultaneous requests: exactly one req_ready. A requester keeps req_valid high until it sees req_ready; fields are sampled only on the accept cycle.
- req_valid dropped before acceptance: the request is ignored with no side effects.

Test Plan:
- Single 3-byte write, req0 chip=2 bytes=AA,BB,CC, spitxready model (drops 1 cycle after dv, back 16 cycles later), spirxdv per byte with spirx=11,22,33 -> spics=8'hFB throughout, spimisossel=2, exactly three spitxdv pulses carrying AA,BB,CC in order, rsp_valid[0] with rsp_data=33 and rsp_err=0, then spics=FF for ≥4 cycles.
- Both requesters valid every cycle for 4 transactions -> grants alternate 0,1,0,1; never two req_ready bits high; rsp_valid goes to the matching owner.
- Read, req1 nbytes=2 chip=5 -> two spitxdv pulses, spics=8'hDF, rsp_data equals the second spirx byte.
- spitxready stuck low -> abort at cycle 1023 of WAIT_RDY, rsp_err=1, rsp_data=FF, spics returns to FF, spitxdv never asserted; the next request then completes normally.
- nbytes=0 request -> rsp_err=1 within 2 cycles of accept, spics and spitxdv never change; rst asserted in the middle of byte 2 of a normal transaction -> spics=FF and spitxdv=0 next cycle, no rsp_valid, pointer=0.
